// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: word width, request mode
// encodings and responder FSM state encodings.
package mem_responder_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
// A request transfers on a rising edge with req_valid & req_ready both high;
// a response transfers on a rising edge with rsp_valid & rsp_ready both high,
// and rsp_* stay stable while rsp_valid is high and rsp_ready is low.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic [1:0]        req_mode;
    logic [15:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_ready;

    modport master (
        output req_valid, req_mode, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_mode, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_store.sv
// DEPTH x WORD_W storage: synchronous write, combinational read at the
// latched index. Contents are deliberately not reset.
module mem_responder_store
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: IDLE -> WAIT -> RESP handshake FSM in front of
// mem_responder_store. Define MEM_RESPONDER_ERR_EN to answer mode 11 and
// out-of-range addresses with an error response instead of ignoring/wrapping.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    output state_t         state_dbg
);

    localparam int IW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q;
    logic              is_write_q, err_q, rsp_err_q;
    logic [IW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q, rdata_q, store_rdata;
    logic              mode_ok, err_now, accept, commit;

`ifdef MEM_RESPONDER_ERR_EN
    assign mode_ok = (bus.req_mode != MODE_NONE);
    assign err_now = (bus.req_mode == MODE_RSVD) || ({1'b0, bus.req_addr} >= 17'(DEPTH));
`else
    logic unused_addr_bits;
    assign mode_ok = (bus.req_mode == MODE_READ) || (bus.req_mode == MODE_WRITE);
    assign err_now = 1'b0;
    assign unused_addr_bits = ^bus.req_addr;
`endif

    // run_q keeps req_ready low until the first edge after reset releases.
    assign bus.req_ready = run_q && (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_dbg     = state_q;
    assign accept        = bus.req_ready && bus.req_valid && mode_ok;

    // WAIT always lasts WAIT+1 cycles (counter runs down to 0, then one more
    // edge), giving rsp_valid exactly WAIT+1 edges after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(WAIT);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                is_write_q <= (bus.req_mode == MODE_WRITE);
                err_q      <= err_now;
                idx_q      <= bus.req_addr[IW-1:0];
                wdata_q    <= bus.req_wdata;
            end
            if (commit) begin
                rdata_q   <= (is_write_q || err_q) ? '0 : store_rdata;
                rsp_err_q <= err_q;
            end
        end
    end

    mem_responder_store #(.DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .we    (commit && is_write_q && !err_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (store_rdata)
    );

endmodule
